// File: rtl/tone_seq_pkg.sv
// Shared state encoding and step-word layout for the tone sequencer.
// A step word is {pitch[7:4], duration[3:0]}; pitch 0 is a rest, duration 0 ends the pattern.
package tone_seq_pkg;

    localparam int PITCH_W   = 4;
    localparam int DUR_W     = 4;
    localparam int STEP_W    = PITCH_W + DUR_W;

    localparam int PITCH_LSB = DUR_W;
    localparam int PITCH_MSB = STEP_W - 1;
    localparam int DUR_LSB   = 0;
    localparam int DUR_MSB   = DUR_W - 1;

    localparam logic [PITCH_W-1:0] PITCH_REST = '0;
    localparam logic [DUR_W-1:0]   DUR_END    = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        DONE
    } seq_state_t;

    function automatic logic [PITCH_W-1:0] step_pitch(input logic [STEP_W-1:0] step);
        return step[PITCH_MSB:PITCH_LSB];
    endfunction

    function automatic logic [DUR_W-1:0] step_dur(input logic [STEP_W-1:0] step);
        return step[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the top-level wrapper (master) and the tone sequencer (slave).
interface tone_sequencer_if #(
    parameter int STEPS = 8
);
    import tone_seq_pkg::*;

    localparam int IDX_W = $clog2(STEPS);

    logic                wr_en;
    logic [IDX_W-1:0]    wr_addr;
    logic [STEP_W-1:0]   wr_data;
    logic                start;
    logic                stop;
    logic                loop_en;

    logic [PITCH_W-1:0]  pitch_out;
    logic                gate_out;
    logic [IDX_W-1:0]    step_idx;
    logic                busy;
    logic                done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop_en,
        input  pitch_out, gate_out, step_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop_en,
        output pitch_out, gate_out, step_idx, busy, done
    );

endinterface

// File: rtl/tone_sequencer_beat_prescaler.sv
// Beat prescaler: counts 0..BEAT_DIV-1 while enabled and pulses tick on the wrap cycle.
// Optional mark pulse flags one fixed count value inside every beat.
module beat_prescaler #(
    parameter int BEAT_DIV = 1000000,
    parameter int MARK_AT  = 0,
    parameter bit MARK_EN  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    input  logic cnt_en,
    output logic tick,
    output logic mark
);

    localparam int               CNT_W    = $clog2(BEAT_DIV);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0] MARK_VAL = CNT_W'(MARK_AT);

    logic [CNT_W-1:0] count_reg;
    logic             active;

    assign active = ena && cnt_en && !clr;
    assign tick   = active && (count_reg == LAST);
    // With MARK_EN clear this folds to a constant and leaves no logic behind.
    assign mark   = MARK_EN && active && (count_reg == MARK_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (ena) begin
            if (clr) begin
                count_reg <= '0;
            end else if (cnt_en) begin
                count_reg <= (count_reg == LAST) ? '0 : count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Step-table tone sequencer driving pitch select and gate of the waveform generator.
// Define TONE_SEQ_ARTIC_EN to mute the gate for the last GAP_CYCLES of every note.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int STEPS      = 8,
    parameter int BEAT_DIV   = 1000000,
    parameter int GAP_CYCLES = 125000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    tone_sequencer_if.slave  seq
);

    localparam int               IDX_W     = $clog2(STEPS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STEPS - 1);
    localparam logic [DUR_W-1:0] LAST_BEAT = DUR_W'(1);

`ifdef TONE_SEQ_ARTIC_EN
    localparam bit ARTIC_EN = (GAP_CYCLES > 0) && (GAP_CYCLES < BEAT_DIV);
`else
    localparam bit ARTIC_EN = 1'b0;
`endif
    // Gate is dropped one cycle ahead so the registered output goes low exactly
    // when the prescaler reaches BEAT_DIV-GAP_CYCLES in the final beat.
    localparam int GAP_START = ARTIC_EN ? (BEAT_DIV - GAP_CYCLES - 1) : 0;

    logic [STEP_W-1:0]  step_mem [STEPS];
    logic [STEP_W-1:0]  rd_step;
    logic [PITCH_W-1:0] rd_pitch;
    logic [DUR_W-1:0]   rd_dur;

    seq_state_t         state_reg;
    logic [DUR_W-1:0]   beat_cnt_reg;
    logic [PITCH_W-1:0] pitch_reg;
    logic               gate_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               presc_clr;
    logic               presc_en;
    logic               beat_tick;
    logic               gap_mark;

    // Table write is a plain NBA, so a LOAD of the same index this cycle sees the old word.
    always_ff @(posedge clk) begin
        if (ena && seq.wr_en) begin
            step_mem[seq.wr_addr] <= seq.wr_data;
        end
    end

    assign rd_step  = step_mem[idx_reg];
    assign rd_pitch = step_pitch(rd_step);
    assign rd_dur   = step_dur(rd_step);

    assign presc_en  = (state_reg == PLAY);
    assign presc_clr = (state_reg != PLAY);

    beat_prescaler #(
        .BEAT_DIV (BEAT_DIV),
        .MARK_AT  (GAP_START),
        .MARK_EN  (ARTIC_EN)
    ) u_beat_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .clr    (presc_clr),
        .cnt_en (presc_en),
        .tick   (beat_tick),
        .mark   (gap_mark)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            pitch_reg    <= '0;
            gate_reg     <= 1'b0;
            idx_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else if (ena) begin
            done_reg <= 1'b0;
            if (seq.stop) begin
                state_reg <= IDLE;
                gate_reg  <= 1'b0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (seq.start) begin
                            state_reg <= LOAD;
                            idx_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end

                    LOAD: begin
                        if (rd_dur == DUR_END) begin
                            if ((idx_reg != '0) && seq.loop_en) begin
                                idx_reg <= '0;
                            end else begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                                gate_reg  <= 1'b0;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            state_reg    <= PLAY;
                            pitch_reg    <= rd_pitch;
                            gate_reg     <= (rd_pitch != PITCH_REST);
                            beat_cnt_reg <= rd_dur;
                        end
                    end

                    PLAY: begin
                        if (gap_mark && (beat_cnt_reg == LAST_BEAT)) begin
                            gate_reg <= 1'b0;
                        end
                        if (beat_tick) begin
                            beat_cnt_reg <= beat_cnt_reg - DUR_W'(1);
                            if (beat_cnt_reg == LAST_BEAT) begin
                                if (idx_reg != LAST_IDX) begin
                                    idx_reg   <= idx_reg + IDX_W'(1);
                                    state_reg <= LOAD;
                                end else if (seq.loop_en) begin
                                    idx_reg   <= '0;
                                    state_reg <= LOAD;
                                end else begin
                                    state_reg <= DONE;
                                    done_reg  <= 1'b1;
                                    gate_reg  <= 1'b0;
                                    busy_reg  <= 1'b0;
                                end
                            end
                        end
                    end

                    DONE: begin
                        state_reg <= IDLE;
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign seq.pitch_out = pitch_reg;
    assign seq.gate_out  = gate_reg;
    assign seq.step_idx  = idx_reg;
    assign seq.busy      = busy_reg;
    assign seq.done      = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: expected output timelines are expanded from the step table
// (one LOAD cycle plus duration*BEAT_DIV play cycles per step) and compared every cycle.
module tb_tone_sequencer;

    localparam int STEPS      = 4;
    localparam int BEAT_DIV   = 4;
    localparam int GAP_CYCLES = 1;
    localparam int IDX_W      = $clog2(STEPS);
`ifdef TONE_SEQ_ARTIC_EN
    localparam bit ARTIC = 1'b1;
`else
    localparam bit ARTIC = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]       pitch;
        logic             gate;
        logic [IDX_W-1:0] idx;
        logic             busy;
        logic             done;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ena   = 1'b1;

    tone_sequencer_if #(.STEPS(STEPS)) sif ();

    tone_sequencer #(
        .STEPS      (STEPS),
        .BEAT_DIV   (BEAT_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .seq   (sif)
    );

    always #5 clk = ~clk;

    obs_t       exp_q [$];
    logic [7:0] mtab [STEPS];
    logic [3:0] m_pitch;
    int         vectors     = 0;
    int         miscompares = 0;

    function automatic obs_t mk(input logic [3:0] p, input logic g, input int i,
                                input logic b, input logic d);
        obs_t r;
        r.pitch = p;
        r.gate  = g;
        r.idx   = IDX_W'(i);
        r.busy  = b;
        r.done  = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input obs_t e);
        obs_t o;
        o = {sif.pitch_out, sif.gate_out, sif.step_idx, sif.busy, sif.done};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s @%0t: observed pitch=%0h gate=%b idx=%0d busy=%b done=%b, expected pitch=%0h gate=%b idx=%0d busy=%b done=%b",
                   tag, $time, o.pitch, o.gate, o.idx, o.busy, o.done,
                   e.pitch, e.gate, e.idx, e.busy, e.done);
        end
    endtask

    task automatic write_entry(input int a, input logic [7:0] d);
        sif.wr_en   = 1'b1;
        sif.wr_addr = IDX_W'(a);
        sif.wr_data = d;
        tick();
        sif.wr_en   = 1'b0;
        mtab[a]     = d;
    endtask

    // Expands the pattern into the per-cycle output timeline seen after each edge,
    // starting with the edge that samples start. A write issued after edge wpos is
    // visible to any LOAD occupying a later cycle.
    function automatic void gen_trace(input bit lp, input int wpos, input int waddr,
                                      input logic [7:0] wdat, input int limit);
        logic [7:0] tab [STEPS];
        logic [3:0] p;
        logic       g;
        int         i, dur, len;
        bit         wdone;
        tab   = mtab;
        p     = m_pitch;
        g     = 1'b0;
        i     = 0;
        wdone = (wpos < 0);
        exp_q.delete();
        exp_q.push_back(mk(p, 1'b0, 0, 1'b1, 1'b0));
        while (exp_q.size() < limit) begin
            if (!wdone && (wpos < exp_q.size() - 1)) begin
                tab[waddr] = wdat;
                wdone      = 1'b1;
            end
            dur = int'(tab[i][3:0]);
            if (dur == 0) begin
                if (i == 0 || !lp) begin
                    exp_q.push_back(mk(p, 1'b0, i, 1'b0, 1'b1));
                    exp_q.push_back(mk(p, 1'b0, i, 1'b0, 1'b0));
                    break;
                end
                i = 0;
                exp_q.push_back(mk(p, g, 0, 1'b1, 1'b0));
                continue;
            end
            p   = tab[i][7:4];
            len = dur * BEAT_DIV;
            for (int k = 0; k < len; k++) begin
                g = (p != 4'h0) && !(ARTIC && (k >= len - GAP_CYCLES));
                exp_q.push_back(mk(p, g, i, 1'b1, 1'b0));
            end
            if (i == STEPS - 1 && !lp) begin
                exp_q.push_back(mk(p, 1'b0, i, 1'b0, 1'b1));
                exp_q.push_back(mk(p, 1'b0, i, 1'b0, 1'b0));
                break;
            end
            i = (i + 1) % STEPS;
            exp_q.push_back(mk(p, g, i, 1'b1, 1'b0));
        end
    endfunction

    task automatic run(input string tag, input bit lp, input int wpos, input int waddr,
                       input logic [7:0] wdat, input int fpos, input bit hold_start,
                       input int limit);
        obs_t e;
        gen_trace(lp, wpos, waddr, wdat, limit);
        if (hold_start) begin
            e = exp_q[exp_q.size() - 1];
            exp_q.push_back(mk(e.pitch, 1'b0, 0, 1'b1, 1'b0));
        end
        sif.loop_en = lp;
        sif.start   = 1'b1;
        tick();
        if (!hold_start) sif.start = 1'b0;
        for (int t = 0; t < exp_q.size(); t++) begin
            if (t > 0) tick();
            sif.wr_en = 1'b0;
            check(tag, exp_q[t]);
            if (t == wpos) begin
                sif.wr_en   = 1'b1;
                sif.wr_addr = IDX_W'(waddr);
                sif.wr_data = wdat;
                mtab[waddr] = wdat;
            end
            if (t == fpos) begin
                ena = 1'b0;
                repeat (10) begin
                    tick();
                    check({tag, "_freeze"}, exp_q[t]);
                end
                ena = 1'b1;
            end
        end
        e       = exp_q[exp_q.size() - 1];
        m_pitch = e.pitch;
        if (lp || hold_start) begin
            sif.start = 1'b0;
            sif.stop  = 1'b1;
            tick();
            sif.stop  = 1'b0;
            sif.wr_en = 1'b0;
            e.gate = 1'b0;
            e.busy = 1'b0;
            e.done = 1'b0;
            check({tag, "_stop"}, e);
            repeat (3) begin
                tick();
                check({tag, "_idle"}, e);
            end
        end
        if (sif.wr_en) begin
            tick();
            sif.wr_en = 1'b0;
        end
    endtask

    initial begin
        sif.wr_en   = 1'b0;
        sif.wr_addr = '0;
        sif.wr_data = '0;
        sif.start   = 1'b0;
        sif.stop    = 1'b0;
        sif.loop_en = 1'b0;
        m_pitch     = 4'h0;

        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("reset", mk(4'h0, 1'b0, 0, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        check("idle", mk(4'h0, 1'b0, 0, 1'b0, 1'b0));

        sif.start = 1'b1;
        sif.stop  = 1'b1;
        tick();
        check("start_with_stop", mk(4'h0, 1'b0, 0, 1'b0, 1'b0));
        sif.start = 1'b0;
        sif.stop  = 1'b0;

        write_entry(0, 8'h31);
        write_entry(1, 8'h52);
        write_entry(2, 8'h01);
        write_entry(3, 8'h00);
        run("plan_once", 1'b0, -1, 0, 8'h00, -1, 1'b0, 200);
        run("plan_loop_freeze", 1'b1, -1, 0, 8'h00, 2, 1'b0, 40);
        run("write_while_play", 1'b1, 2, 0, 8'hA2, -1, 1'b0, 45);

        write_entry(0, 8'h70);
        run("empty_pattern", 1'b1, -1, 0, 8'h00, -1, 1'b0, 10);

        // Write lands on the very cycle step 1 is loaded: the old word must play.
        write_entry(0, 8'h32);
        write_entry(1, 8'h42);
        write_entry(2, 8'h63);
        write_entry(3, 8'h00);
        run("read_before_write", 1'b0, 9, 1, 8'h93, -1, 1'b0, 200);
        run("start_held", 1'b0, -1, 0, 8'h00, -1, 1'b1, 200);

        for (int tr = 0; tr < 6; tr++) begin
            int         endpos;
            logic [7:0] ent;
            bit         lp;
            endpos = $urandom_range(1, STEPS);
            for (int a = 0; a < STEPS; a++) begin
                ent = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 3))};
                if (a == endpos) ent[3:0] = 4'h0;
                write_entry(a, ent);
            end
            lp = 1'($urandom_range(0, 1));
            run("random", lp, $urandom_range(1, 12), $urandom_range(0, STEPS - 1),
                8'($urandom_range(0, 255)), $urandom_range(13, 20), 1'b0, 50);
        end

        write_entry(0, 8'h52);
        write_entry(1, 8'h21);
        gen_trace(1'b1, -1, 0, 8'h00, 30);
        sif.loop_en = 1'b1;
        sif.start   = 1'b1;
        tick();
        sif.start   = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) tick();
            check("pre_reset", exp_q[t]);
        end
        #2 rst_n = 1'b0;
        #1 check("async_reset", mk(4'h0, 1'b0, 0, 1'b0, 1'b0));
        tick();
        check("reset_held", mk(4'h0, 1'b0, 0, 1'b0, 1'b0));
        #3 rst_n = 1'b1;
        tick();
        check("after_reset", mk(4'h0, 1'b0, 0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
